// File: rtl/bcd_display_mux_if.sv
// Display bus: packed BCD load on one side, scanned 7-segment drive on the other.
// master drives bcd/cargar and watches the display; slave is the driver block.
interface bcd_display_mux_if;
  logic [15:0] bcd;
  logic        cargar;
  logic [6:0]  segmentos;
  logic [3:0]  anodos;
  logic        error;

  modport master (
    output bcd, cargar,
    input  segmentos, anodos, error
  );

  modport slave (
    input  bcd, cargar,
    output segmentos, anodos, error
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Multiplexed 4-digit 7-segment driver with frame-synchronous value update.
// Ports: clk, rst (sync, active-high), bus (slave: bcd/cargar in, segs/anodes/error out).
module bcd_display_mux #(
  parameter int REFRESH_DIV    = 6750,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_display_mux_if.slave   bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_q, pend_d;
  logic          pok_q, pok_d;
  logic [15:0]   most_q, most_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          err_q, err_d;

  logic       tick;
  logic [3:0] nib;
  logic [6:0] seg_raw;
  logic       z1, z2, z3;
  logic       blank;

  always_comb begin
    tick    = (presc_q == LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    pend_d = pend_q;
    pok_d  = pok_q;
    most_d = most_q;
    if (tick && idx_q == 2'd3 && pok_q) begin
      most_d = pend_q;
      pok_d  = 1'b0;
    end
    // A load on the boundary edge lands after the transfer above.
    if (bus.cargar) begin
      pend_d = bus.bcd;
      pok_d  = 1'b1;
    end

    nib = most_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'd0:    seg_raw = 7'b0111111;
      4'd1:    seg_raw = 7'b0000110;
      4'd2:    seg_raw = 7'b1011011;
      4'd3:    seg_raw = 7'b1001111;
      4'd4:    seg_raw = 7'b1100110;
      4'd5:    seg_raw = 7'b1101101;
      4'd6:    seg_raw = 7'b1111101;
      4'd7:    seg_raw = 7'b0000111;
      4'd8:    seg_raw = 7'b1111111;
      4'd9:    seg_raw = 7'b1101111;
      default: seg_raw = 7'b1000000;
    endcase

    // zK: nibbles K..3 are all zero.
    z3 = (most_q[15:12] == 4'd0);
    z2 = z3 && (most_q[11:8] == 4'd0);
    z1 = z2 && (most_q[7:4] == 4'd0);
    blank = 1'b0;
    unique case (1'b1)
      (idx_q == 2'd1): blank = z1;
      (idx_q == 2'd2): blank = z2;
      (idx_q == 2'd3): blank = z3;
      default:         blank = 1'b0;
    endcase
    blank = blank && BLANK_LZ;

    err_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (most_q[4*k +: 4] > 4'd9) err_d = 1'b1;
    end

    if (blank) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      an_d  = AN_ACTIVE_LOW ? ~(4'b0001 << idx_q)
                            :  (4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      pend_q  <= 16'h0000;
      pok_q   <= 1'b0;
      most_q  <= 16'h0000;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pok_q   <= pok_d;
      most_q  <= most_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      err_q   <= err_d;
    end
  end

  assign bus.segmentos = seg_q;
  assign bus.anodos    = an_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux, REFRESH_DIV=4.
// Runs a blanking and a non-blanking instance side by side.
module tb_bcd_display_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_display_mux_if b1 ();
  bcd_display_mux_if b2 ();

  bcd_display_mux #(.REFRESH_DIV(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  bcd_display_mux #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  int pass_n = 0;
  int tot_n  = 0;
  int cnt    = 0;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [27:0] Z1   = {BL, BL, BL, 7'h40};
  localparam logic [27:0] Z2   = {4{7'h40}};
  localparam logic [27:0] V1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] S7_1 = {BL, BL, BL, 7'h78};
  localparam logic [27:0] S7_2 = {7'h40, 7'h40, 7'h40, 7'h78};
  localparam logic [27:0] A5_1 = {BL, BL, 7'h3F, 7'h12};
  localparam logic [27:0] A5_2 = {7'h40, 7'h40, 7'h3F, 7'h12};
  localparam logic [27:0] S5_1 = {BL, BL, BL, 7'h12};
  localparam logic [27:0] S5_2 = {7'h40, 7'h40, 7'h40, 7'h12};
  localparam logic [27:0] V2222 = {4{7'h24}};
  localparam logic [27:0] V9876 = {7'h10, 7'h00, 7'h78, 7'h02};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic drive(input logic ld, input logic [15:0] v);
    b1.cargar = ld;
    b1.bcd    = v;
    b2.cargar = ld;
    b2.bcd    = v;
  endtask

  function automatic logic [3:0] an_of(input logic [6:0] s, input int d);
    if (s == BL) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  task automatic look(input logic [27:0] s1, input logic [27:0] s2,
                      input logic e);
    int d;
    logic [6:0] x1, x2;
    d  = ((cnt - 1) / 4) % 4;
    x1 = s1[7*d +: 7];
    x2 = s2[7*d +: 7];
    check($sformatf("seg1@%0d", cnt), 32'(b1.segmentos), 32'(x1));
    check($sformatf("an1@%0d", cnt), 32'(b1.anodos), 32'(an_of(x1, d)));
    check($sformatf("err1@%0d", cnt), 32'(b1.error), 32'(e));
    check($sformatf("seg2@%0d", cnt), 32'(b2.segmentos), 32'(x2));
    check($sformatf("an2@%0d", cnt), 32'(b2.anodos), 32'(an_of(x2, d)));
    check($sformatf("err2@%0d", cnt), 32'(b2.error), 32'(e));
  endtask

  task automatic look_rst(input string tag);
    check({tag, "_an1"}, 32'(b1.anodos), 32'h0000000F);
    check({tag, "_seg1"}, 32'(b1.segmentos), 32'h0000007F);
    check({tag, "_err1"}, 32'(b1.error), 32'h0);
    check({tag, "_an2"}, 32'(b2.anodos), 32'h0000000F);
    check({tag, "_seg2"}, 32'(b2.segmentos), 32'h0000007F);
    check({tag, "_err2"}, 32'(b2.error), 32'h0);
  endtask

  task automatic cyc(input logic [27:0] s1, input logic [27:0] s2,
                     input logic e, input logic ld, input logic [15:0] v);
    drive(ld, v);
    step;
    drive(1'b0, v);
    look(s1, s2, e);
  endtask

  task automatic frame(input logic [27:0] s1, input logic [27:0] s2,
                       input logic e,
                       input int oa, input logic [15:0] va,
                       input int ob, input logic [15:0] vb);
    for (int i = 0; i < 16; i++) begin
      cyc(s1, s2, e, (i == oa) || (i == ob), (i == ob) ? vb : va);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      step;
      look_rst("reset");
    end
    rst = 1'b0;
    drive(1'b0, 16'h0000);
    cnt = 0;

    frame(Z1, Z2, 1'b0, 0, 16'h1234, -1, 16'h0);
    frame(V1234, V1234, 1'b0, 3, 16'h0007, -1, 16'h0);
    frame(S7_1, S7_2, 1'b0, 14, 16'h0000, -1, 16'h0);
    frame(Z1, Z2, 1'b0, 8, 16'h00A5, -1, 16'h0);
    frame(A5_1, A5_2, 1'b1, 2, 16'h0005, -1, 16'h0);
    frame(S5_1, S5_2, 1'b0, 5, 16'h1111, 7, 16'h2222);
    frame(V2222, V2222, 1'b0, 15, 16'h9876, -1, 16'h0);
    frame(V2222, V2222, 1'b0, -1, 16'h0, -1, 16'h0);
    frame(V9876, V9876, 1'b0, -1, 16'h0, -1, 16'h0);

    cyc(V9876, V9876, 1'b0, 1'b1, 16'h4321);
    cyc(V9876, V9876, 1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    step;
    look_rst("midrst");
    rst = 1'b0;
    cnt = 0;
    frame(Z1, Z2, 1'b0, -1, 16'h0, -1, 16'h0);
    frame(Z1, Z2, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Multiplexed 4-digit seven-segment display driver that consumes the 16-bit packed BCD word produced by the binary-to-BCD converter and drives the keypad board's common-anode display. A pending register accepts new values at any time. The visible value updates only at frame boundaries, so a frame never mixes digits from two values. The block scans one digit per refresh slot, blanks leading zeros, and flags non-BCD nibbles.

## Interface
- REFRESH_DIV, 6750: clock cycles per digit slot. Must be ≥ 2. 27 MHz / 6750 gives a 4 kHz digit rate and a 1 kHz frame rate.
- BLANK_LZ, 1: 1 enables leading-zero blanking. 0 shows all four digits.
- SEG_ACTIVE_LOW, 1: 1 inverts the segment outputs.
- AN_ACTIVE_LOW, 1: 1 inverts the anode outputs.

- clk  in  1  system clock
- rst  in  1  reset. Synchronous and active-high; one clock, no other clock domain.
- bcd  in  16  packed BCD value. [3:0] is units, [15:12] is thousands.
- cargar  in  1  load strobe. bcd is sampled on any cycle where cargar=1.
- segmentos  out  7  segment drive, bit order {g,f,e,d,c,b,a}. Registered.
- anodos  out  4  digit enables. Bit k drives digit k (0 = units). At most one is active. Registered.
- error  out  1  high while the displayed value has any nibble > 9. Registered.

## Operation
- Registers:
  - prescaler: 0..REFRESH_DIV-1.
  - indice: 2 bits, digit index.
  - pendiente: 16 bits, plus a pend_ok flag.
  - mostrado: 16 bits, the displayed value.
- Load path:
  - On cargar=1: pendiente←bcd and pend_ok←1.
  - Repeated loads within one frame overwrite pendiente. The last one wins.
- Prescaler:
  - Increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and asserts an internal tick.
  - On tick, indice increments, wrapping 3→0.
- Frame boundary: a tick with indice=3.
  - If pend_ok: mostrado←pendiente and pend_ok←0.
  - If cargar=1 on that same cycle, the incoming bcd goes to pendiente. pend_ok stays 1, so that value is shown at the next boundary.
- Digit decode uses nibble n = mostrado[4k+3:4k], where k=indice:
  - n = 0..9 drives the standard pattern. Active-high gfedcba codes:
    - 0: 0111111
    - 1: 0000110
    - 2: 1011011
    - 3: 1001111
    - 4: 1100110
    - 5: 1101101
    - 6: 1111101
    - 7: 0000111
    - 8: 1111111
    - 9: 1101111
  - n = 10..15 drives a dash, 1000000.
- Blanking: digit k (k ≥ 1) is blanked when BLANK_LZ=1 and nibbles k..3 of mostrado are all zero.
  - A blanked slot drives anodos all inactive and segmentos all off. The slot time is still consumed.
  - Digit 0 is never blanked.
- error = OR over k of (mostrado nibble k > 9), registered.
- The polarity parameters are applied last, at the output registers.

## Timing
- Reset (rst=1 at a clock edge):
  - prescaler, indice, pendiente, pend_ok and mostrado all clear to 0.
  - anodos is all inactive (4'hF when active-low).
  - segmentos is all off (7'h7F when active-low).
  - error is 0.
  - Reset asserted mid-frame discards both mostrado and any pending load on that edge.
- First edge after rst falls: outputs register digit 0 of mostrado=0. With default parameters, anodos=4'hE and segmentos=7'h40.
- Output latency: segmentos, anodos and error follow indice and mostrado by exactly one clock.
- Digit dwell: exactly REFRESH_DIV cycles per slot. The frame is 4×REFRESH_DIV cycles.
- Load-to-display latency:
  - Measured from the cargar edge to the first output reflecting the new value.
  - Maximum is 4×REFRESH_DIV+1 cycles.
  - Minimum is 2, when the load lands on the boundary-minus-one cycle.
- cargar asserted on the boundary edge itself misses that boundary and is shown at the following one.

## Test plan
All scenarios use REFRESH_DIV=4 and default polarities.

- **Reset:**
  - Hold rst for 3 cycles with cargar=1 and bcd=16'h1234.
  - Required: anodos=4'hF, segmentos=7'h7F, error=0 throughout.
  - Required: the first frame after release shows "0" on digit 0 only.
- **Basic scan:**
  - Pulse cargar with 16'h1234, then wait for a boundary.
  - Required: anodos cycles 4'hE/D/B/7, each held 4 cycles.
  - Required: segmentos is 7'h19/30/24/79 for digits 4, 3, 2, 1 respectively. error=0.
- **Leading-zero blanking:**
  - Load 16'h0007. Required: digit 0 slot shows anodos=4'hE with segmentos=7'h78. The other three slots show anodos=4'hF.
  - Load 16'h0000. Required: only digit 0 shows, with segmentos=7'h40.
  - Repeat with BLANK_LZ=0. Required: all four digits show 7'h40.
- **Non-BCD:**
  - Load 16'h00A5.
  - Required: digit 0 shows 7'h12 and digit 1 shows 7'h3F. Digits 2 and 3 are blanked.
  - Required: error=1 from one cycle after the boundary until a valid value is displayed.
- **No tearing / last-wins:**
  - Mid-frame, load 16'h1111, then 16'h2222 two cycles later.
  - Required: no slot ever shows "1". The next full frame shows 2222 on all four digits.
- **Boundary-edge load and mid-frame reset:**
  - Assert cargar exactly on the boundary edge. Required: the new value appears only after the next boundary.
  - Assert rst for one cycle mid-slot. Required: the output state matches the reset scenario, and the pending value is lost.
